// File: rtl/param_deserializer.sv
// Serial-to-parallel converter for the UART Rx path: gathers WIDTH bits in either
// bit order, optionally checks a trailing parity bit, and hands each word out on valid/ready.
module param_deserializer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             frame_start,
    input  logic             deser_en,
    input  logic             sampled_bit,
    input  logic             msb_first,
    input  logic             par_en,
    input  logic             par_typ,
    output logic [WIDTH-1:0] P_DATA,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             par_err,
    output logic             overrun,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, DATA, PAR} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic [CNT_W-1:0] cnt_reg;
    logic             acc_reg, msb_reg, par_en_reg, par_typ_reg;
    logic             done_reg, done_err_reg;
    logic [WIDTH-1:0] done_word_reg;
    logic             last_bit, complete, complete_err;
    logic [WIDTH-1:0] complete_word;

    always_comb begin
        shift_next = msb_reg ? {shift_reg[WIDTH-2:0], sampled_bit}
                             : {sampled_bit, shift_reg[WIDTH-1:1]};
        last_bit   = (cnt_reg == CNT_LAST);
    end

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    // Next-state logic; frame_start restarts collection from any state
    always_comb begin
        state_next = state_reg;
        if (frame_start) begin
            state_next = DATA;
        end else begin
            case (state_reg)
                DATA:    if (deser_en && last_bit) state_next = par_en_reg ? PAR : IDLE;
                PAR:     if (deser_en) state_next = IDLE;
                default: state_next = state_reg;
            endcase
        end
    end

    // Output logic: completion strobe and the word/error it carries
    always_comb begin
        busy          = (state_reg != IDLE);
        complete      = 1'b0;
        complete_word = shift_next;
        complete_err  = 1'b0;
        if (!frame_start && deser_en) begin
            if (state_reg == DATA && last_bit && !par_en_reg) begin
                complete = 1'b1;
            end else if (state_reg == PAR) begin
                complete      = 1'b1;
                complete_word = shift_reg;
                complete_err  = sampled_bit ^ acc_reg ^ par_typ_reg;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shift_reg   <= '0;
            cnt_reg     <= '0;
            acc_reg     <= 1'b0;
            msb_reg     <= 1'b0;
            par_en_reg  <= 1'b0;
            par_typ_reg <= 1'b0;
        end else if (frame_start) begin
            shift_reg   <= '0;
            cnt_reg     <= '0;
            acc_reg     <= 1'b0;
            msb_reg     <= msb_first;
            par_en_reg  <= par_en;
            par_typ_reg <= par_typ;
        end else if (state_reg == DATA && deser_en) begin
            shift_reg <= shift_next;
            acc_reg   <= acc_reg ^ sampled_bit;
            if (cnt_reg != CNT_MAX) cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    // Completion is staged one cycle before it reaches the output register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            done_reg      <= 1'b0;
            done_word_reg <= '0;
            done_err_reg  <= 1'b0;
        end else begin
            done_reg      <= complete;
            done_word_reg <= complete_word;
            done_err_reg  <= complete_err;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            P_DATA     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done_reg) begin
                if (!data_valid || data_ready) begin
                    P_DATA     <= done_word_reg;
                    par_err    <= done_err_reg;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_param_deserializer.sv
// Randomized and directed bench for param_deserializer: stimulus pushes expected words into
// a scoreboard queue, an independent monitor pops and compares on every accepted word.
module tb_param_deserializer;

    localparam int WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] word;
        logic             err;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             frame_start = 1'b0, deser_en = 1'b0, sampled_bit = 1'b0;
    logic             msb_first = 1'b0, par_en = 1'b0, par_typ = 1'b0, data_ready = 1'b0;
    logic [WIDTH-1:0] p_data;
    logic             data_valid, par_err, overrun, busy;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;
    int   ovr_seen = 0;
    int   exp_ovr = 0;

    param_deserializer #(.WIDTH(WIDTH), .CNT_W(4)) dut (
        .CLK(clk), .RST(rst_n), .frame_start(frame_start), .deser_en(deser_en),
        .sampled_bit(sampled_bit), .msb_first(msb_first), .par_en(par_en), .par_typ(par_typ),
        .P_DATA(p_data), .data_valid(data_valid), .data_ready(data_ready),
        .par_err(par_err), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected parity error: the parity bit must equal XOR of data (even) or its inverse (odd)
    function automatic logic model_err(input logic [WIDTH-1:0] w, input logic pe, input logic pt,
                                       input logic pbit);
        int ones = 0;
        logic want;
        if (!pe) return 1'b0;
        for (int i = 0; i < WIDTH; i++) ones += int'(w[i]);
        want = (ones % 2 == 1) ? ~pt : pt;
        return pbit != want;
    endfunction

    task automatic send_frame(input logic [WIDTH-1:0] w, input logic msb, input logic pe,
                              input logic pt, input logic pbit, input bit push,
                              input bit collide, input bit gaps);
        frame_start = 1'b1;
        msb_first   = msb;
        par_en      = pe;
        par_typ     = pt;
        if (collide) begin
            deser_en    = 1'b1;
            sampled_bit = msb ? ~w[WIDTH-1] : ~w[0];
        end
        tick();
        frame_start = 1'b0;
        deser_en    = 1'b0;
        msb_first   = 1'($urandom);
        par_en      = 1'($urandom);
        par_typ     = 1'($urandom);
        for (int i = 0; i < WIDTH; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            deser_en    = 1'b1;
            sampled_bit = msb ? w[WIDTH-1-i] : w[i];
            tick();
            deser_en = 1'b0;
        end
        if (pe) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            deser_en    = 1'b1;
            sampled_bit = pbit;
            tick();
            deser_en = 1'b0;
        end
        if (push) sb.push_back('{w, model_err(w, pe, pt, pbit)});
    endtask

    // Monitor: compare every accepted word against the scoreboard head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (overrun) ovr_seen++;
            if (data_valid && data_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_word", {23'd0, par_err, p_data}, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("word", 32'(p_data), 32'(e.word));
                    chk("par_err", 32'(par_err), 32'(e.err));
                end
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wait_cnt;
        logic [WIDTH-1:0] w;
        logic pe, pt, pbit;

        // Reset state
        tick();
        tick();
        chk("rst_p_data", 32'(p_data), 32'h0);
        chk("rst_valid", 32'(data_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        chk("rst_par_err", 32'(par_err), 32'h0);
        rst_n = 1'b1;
        tick();

        // 1: LSB first, no parity, latency check
        data_ready = 1'b1;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("lat_valid_low", 32'(data_valid), 32'h0);
        chk("busy_done", 32'(busy), 32'h0);
        tick();
        chk("lat_valid_high", 32'(data_valid), 32'h1);
        chk("lat_p_data", 32'(p_data), 32'hA5);
        tick();
        chk("valid_after_accept", 32'(data_valid), 32'h0);

        // 2: MSB first
        send_frame(8'hB2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) tick();

        // 3: parity variants
        send_frame(8'h0F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) tick();
        send_frame(8'h0F, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) tick();
        send_frame(8'h0F, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) tick();

        // 4: overrun while consumer stalls
        data_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("ovr_pulse", 32'(overrun), 32'h1);
        chk("ovr_keep_word", 32'(p_data), 32'h11);
        exp_ovr++;
        tick();
        chk("ovr_one_cycle", 32'(overrun), 32'h0);
        data_ready = 1'b1;
        tick();
        tick();
        chk("ovr_valid_fall", 32'(data_valid), 32'h0);

        // 5: new word lands in the same cycle the old one is accepted
        data_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (2) tick();
        send_frame(8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        data_ready = 1'b1;
        tick();
        chk("swap_p_data", 32'(p_data), 32'h33);
        chk("swap_valid", 32'(data_valid), 32'h1);
        chk("swap_no_ovr", 32'(overrun), 32'h0);
        repeat (2) tick();

        // 6: reset mid-frame, then a clean frame; then frame_start colliding with a strobe
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            deser_en = 1'b1;
            sampled_bit = 1'b1;
            tick();
        end
        deser_en = 1'b0;
        chk("busy_mid_frame", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #2;
        chk("async_rst_busy", 32'(busy), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) tick();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (3) tick();
        send_frame(8'hC3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (3) tick();

        // Randomized frames with gaps and stray strobes while idle
        for (int n = 0; n < 40; n++) begin
            w    = WIDTH'($urandom_range(0, 255));
            pe   = 1'($urandom);
            pt   = 1'($urandom);
            pbit = 1'($urandom);
            send_frame(w, 1'($urandom), pe, pt, pbit, 1'b1, bit'($urandom_range(0, 3) == 0), 1'b1);
            repeat ($urandom_range(0, 3)) begin
                deser_en    = 1'($urandom);
                sampled_bit = 1'($urandom);
                tick();
            end
            deser_en = 1'b0;
            tick();
        end

        wait_cnt = 0;
        while (sb.size() != 0 && wait_cnt < 50) begin
            tick();
            wait_cnt++;
        end
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);
        chk("overrun_count", 32'(ovr_seen), 32'(exp_ovr));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
